textlcd_axil_slave: RTL and testbench

AXI4-Lite responder (slave) for the text-LCD peripheral. It holds four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC, which the PS master writes and reads back. It drives the register contents and per-register write pulses to the downstream LCD timing logic. The block keeps one write and one read outstanding; the two channels are independent.

---
 rtl/textlcd_axil_slave.sv | 118 +++++++++++
 tb/tb_textlcd_axil_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/textlcd_axil_slave.sv
// AXI4-Lite register slave for the text-LCD peripheral: four 32-bit R/W registers
// at offsets 0x0..0xC, mirrored to the LCD timing logic with per-register commit pulses.
module textlcd_axil_slave #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [C_DATA_WIDTH-1:0]   reg0_out,
    output logic [C_DATA_WIDTH-1:0]   reg1_out,
    output logic [C_DATA_WIDTH-1:0]   reg2_out,
    output logic [C_DATA_WIDTH-1:0]   reg3_out,
    output logic [3:0]                wr_pulse
);

    localparam int NB = C_DATA_WIDTH / 8;

    logic                          reset_d;
    logic                          aw_full;
    logic                          w_full;
    logic [1:0]                    aw_idx;
    logic [C_DATA_WIDTH-1:0]       w_data;
    logic [NB-1:0]                 w_strb;
    logic [3:0][C_DATA_WIDTH-1:0]  regs;
    logic [C_DATA_WIDTH-1:0]       merged;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          unused_ok;

    // Protection bits and address bits outside [3:2] carry no meaning here.
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = !reset_d && !aw_full && !s_axi_bvalid;
    assign s_axi_wready  = !reset_d && !w_full && !s_axi_bvalid;
    assign s_axi_arready = !reset_d && !s_axi_rvalid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rresp   = 2'b00;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    assign reg0_out = regs[0];
    assign reg1_out = regs[1];
    assign reg2_out = regs[2];
    assign reg3_out = regs[3];

    always_comb begin
        merged = regs[aw_idx];
        for (int b = 0; b < NB; b++)
            if (w_strb[b]) merged[8*b +: 8] = w_data[8*b +: 8];
    end

    always_ff @(posedge clock) begin
        reset_d <= reset;
        if (reset) begin
            regs         <= '0;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            wr_pulse     <= '0;
        end else begin
            wr_pulse <= '0;
            if (aw_hs) begin
                aw_idx  <= s_axi_awaddr[3:2];
                aw_full <= 1'b1;
            end
            if (w_hs) begin
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
                w_full <= 1'b1;
            end
            // Commit only once both halves are buffered; bvalid blocks new captures.
            if (aw_full && w_full) begin
                regs[aw_idx] <= merged;
                if (|w_strb) wr_pulse[aw_idx] <= 1'b1;
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                s_axi_bvalid <= 1'b1;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            // Same-edge commit to the same register leaves rdata with the old value.
            if (ar_hs) begin
                s_axi_rdata  <= regs[s_axi_araddr[3:2]];
                s_axi_rvalid <= 1'b1;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_textlcd_axil_slave.sv
// Self-checking bench for textlcd_axil_slave: directed protocol scenarios followed by
// randomized writes/reads scored against a byte-mask register model.
module tb_textlcd_axil_slave;

    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] s_axi_awaddr;
    logic [2:0]    s_axi_awprot;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [AW-1:0] s_axi_araddr;
    logic [2:0]    s_axi_arprot;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [31:0]   reg0_out, reg1_out, reg2_out, reg3_out;
    logic [3:0]    wr_pulse;

    textlcd_axil_slave #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg0_out(reg0_out), .reg1_out(reg1_out), .reg2_out(reg2_out), .reg3_out(reg3_out),
        .wr_pulse(wr_pulse)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_out(input int k);
        case (k)
            0: return reg0_out;
            1: return reg1_out;
            2: return reg2_out;
            default: return reg3_out;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // lead > 0: W is offered lead cycles before AW; lead < 0: AW leads W.
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input bit hold_b);
        int cyc = 0;
        int lat = 0;
        int idx;
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        logic [31:0] mask;
        idx = int'(addr[3:2]);
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_axi_wvalid  = !w_done  && (cyc >= (lead < 0 ? -lead : 0));
            s_axi_awvalid = !aw_done && (cyc >= (lead > 0 ? lead : 0));
            aw_go = s_axi_awvalid && s_axi_awready;
            w_go  = s_axi_wvalid && s_axi_wready;
            tick();
            cyc++;
            if (aw_go) aw_done = 1;
            if (w_go)  w_done = 1;
        end
        s_axi_awvalid = 0;
        s_axi_wvalid  = 0;
        chk("wr_handshakes", {30'd0, aw_done, w_done}, 32'd3);
        while (!s_axi_bvalid && lat < 20) begin
            tick();
            lat++;
        end
        chk("b_latency", 32'(lat), 32'd1);
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
        model[idx] = (model[idx] & ~mask) | (data & mask);
        chk("wr_pulse", {28'd0, wr_pulse}, (strb == 4'd0) ? 32'd0 : (32'd1 << idx));
        chk("bresp", {30'd0, s_axi_bresp}, 32'd0);
        chk("reg_after_wr", reg_out(idx), model[idx]);
        if (!hold_b) begin
            s_axi_bready = 1;
            tick();
            s_axi_bready = 0;
            chk("bvalid_drop", {31'd0, s_axi_bvalid}, 32'd0);
            chk("pulse_once", {28'd0, wr_pulse}, 32'd0);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int rdelay);
        int cyc = 0;
        bit done = 0, go;
        logic [31:0] exp;
        exp = model[int'(addr[3:2])];
        s_axi_araddr = addr;
        while (!done && cyc < 50) begin
            s_axi_arvalid = 1;
            go = s_axi_arready;
            tick();
            cyc++;
            if (go) done = 1;
        end
        s_axi_arvalid = 0;
        chk("ar_handshake", {31'd0, done}, 32'd1);
        chk("rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        chk("rdata", s_axi_rdata, exp);
        chk("rresp", {30'd0, s_axi_rresp}, 32'd0);
        for (int i = 0; i < rdelay; i++) begin
            tick();
            chk("rdata_hold", s_axi_rdata, exp);
            chk("arready_hold", {31'd0, s_axi_arready}, 32'd0);
            chk("rvalid_hold", {31'd0, s_axi_rvalid}, 32'd1);
        end
        s_axi_rready = 1;
        tick();
        s_axi_rready = 0;
        chk("rvalid_drop", {31'd0, s_axi_rvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rnd;
        reset = 1;
        s_axi_awaddr = '0; s_axi_awprot = 3'b010; s_axi_awvalid = 0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_araddr = '0; s_axi_arprot = 3'b101; s_axi_arvalid = 0; s_axi_rready = 0;
        for (int k = 0; k < 4; k++) model[k] = '0;
        tick();
        tick();
        reset = 0;

        // Reset state; ready held low for one more cycle.
        chk("rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'd0);
        chk("rst_pulse", {28'd0, wr_pulse}, 32'd0);
        chk("rst_awready", {31'd0, s_axi_awready}, 32'd0);
        chk("rst_arready", {31'd0, s_axi_arready}, 32'd0);
        for (int k = 0; k < 4; k++) chk("rst_reg", reg_out(k), 32'd0);
        tick();
        chk("ready_after_rst", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);

        // Sequential write then readback.
        for (int k = 0; k < 4; k++) do_write(AW'(4 * k), 32'(k + 1), 4'hF, 0, 0);
        for (int k = 0; k < 4; k++) do_read(AW'(4 * k), 0);
        for (int k = 0; k < 4; k++) chk("seq_val", reg_out(k), 32'(k + 1));

        // W leads AW by three cycles.
        do_write(8'h08, 32'hDEADBEEF, 4'hF, 3, 0);
        chk("w_first_reg2", reg2_out, 32'hDEADBEEF);
        do_write(8'h0C, 32'h0BADF00D, 4'hF, -2, 0);

        // Byte strobes and an empty strobe.
        do_write(8'h04, 32'h11223344, 4'hF, 0, 0);
        do_write(8'h04, 32'hAABBCCDD, 4'b0101, 0, 0);
        chk("strb_merge", reg1_out, 32'h11BB33DD);
        do_write(8'h04, 32'hFFFFFFFF, 4'b0000, 0, 0);
        chk("strb_zero", reg1_out, 32'h11BB33DD);

        // B backpressure with a second AW waiting.
        do_write(8'h08, 32'h12345678, 4'hF, 0, 1);
        s_axi_awaddr = 8'h00;
        s_axi_awvalid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
            chk("bp_awready", {31'd0, s_axi_awready}, 32'd0);
            chk("bp_wready", {31'd0, s_axi_wready}, 32'd0);
            tick();
        end
        s_axi_bready = 1;
        chk("bp_awready_bready", {31'd0, s_axi_awready}, 32'd0);
        tick();
        s_axi_bready = 0;
        s_axi_awvalid = 0;
        chk("bp_released", {30'd0, s_axi_bvalid, s_axi_awready}, 32'd1);

        // R backpressure.
        do_read(8'h08, 4);

        // Collision: read of reg0 loads on the same edge the write commits.
        chk("col_pre", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
        s_axi_awaddr = 8'h00; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_araddr = 8'h00; s_axi_arvalid = 1;
        chk("col_arready", {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_arvalid = 0;
        chk("col_rdata_old", s_axi_rdata, 32'h1);
        chk("col_rvalid_bvalid", {30'd0, s_axi_rvalid, s_axi_bvalid}, 32'd3);
        chk("col_reg0", reg0_out, 32'h55);
        model[0] = 32'h55;
        s_axi_bready = 1; s_axi_rready = 1;
        tick();
        s_axi_bready = 0; s_axi_rready = 0;
        do_read(8'h00, 0);

        // Address aliasing above 0x0C.
        do_write(8'h34, 32'hCAFE0001, 4'hF, 0, 0);
        chk("alias_reg1", reg1_out, 32'hCAFE0001);
        do_read(8'hF4, 1);

        // Reset while a response is pending.
        do_write(8'h0C, 32'hA5A5A5A5, 4'hF, 0, 1);
        reset = 1;
        tick();
        reset = 0;
        for (int k = 0; k < 4; k++) model[k] = '0;
        chk("rst2_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        for (int k = 0; k < 4; k++) chk("rst2_reg", reg_out(k), 32'd0);
        chk("rst2_awready", {31'd0, s_axi_awready}, 32'd0);
        tick();
        chk("rst2_awready_next", {31'd0, s_axi_awready}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                rnd = $urandom;
                case ($urandom_range(3, 0))
                    0: s_axi_wstrb = 4'h0;
                    1: s_axi_wstrb = 4'hF;
                    default: s_axi_wstrb = rnd[3:0];
                endcase
                do_write(AW'($urandom_range(255, 0)), $urandom, s_axi_wstrb,
                         int'($urandom_range(6, 0)) - 3, 0);
            end else begin
                do_read(AW'($urandom_range(255, 0)), int'($urandom_range(3, 0)));
            end
        end
        for (int k = 0; k < 4; k++) do_read(AW'(4 * k), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
